// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer sharing one start/done multiplier
// between NREQ requesters. Captures operands on grant, starts the multiplier,
// waits for done or timeout, strobes the result back to the owner, then
// re-arms the multiplier with a one-cycle reset pulse.
module mul_share_ctrl #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   a_in,
  input  logic [NREQ*W-1:0]   b_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [2*W-1:0]      rsp_product,
  output logic                rsp_err,
  output logic                busy,
  output logic                mul_rst_n,
  output logic                mul_start,
  output logic [W-1:0]        mul_data1,
  output logic [W-1:0]        mul_data2,
  input  logic [2*W-1:0]      mul_product,
  input  logic                mul_done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned PW = 2 * W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] gnt_d;
  logic [NREQ-1:0] rsp_valid_d;
  logic [PW-1:0]   rsp_product_d;
  logic            rsp_err_d;
  logic            busy_d;
  logic            mul_rst_n_d;
  logic            mul_start_d;
  logic [W-1:0]    mul_data1_d;
  logic [W-1:0]    mul_data2_d;

  logic            arb_found;
  logic [IW-1:0]   arb_sel;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic [IW-1:0]   ptr_next;

  // Round-robin pick: first set req bit at or after the pointer, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + off) % NREQ;
      if (!arb_found && req[IW'(idx)]) begin
        arb_found = 1'b1;
        arb_sel   = IW'(idx);
      end
    end
  end

  // Operand mux for the selected requester and the pointer that follows it
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_sel == IW'(i)) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
    ptr_next = (arb_sel == IW'(NREQ - 1)) ? '0 : arb_sel + IW'(1);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    rsp_product_d = rsp_product;
    rsp_err_d     = rsp_err;
    mul_rst_n_d   = 1'b1;
    mul_start_d   = mul_start;
    mul_data1_d   = mul_data1;
    mul_data2_d   = mul_data2;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          gnt_d       = NREQ'(1) << arb_sel;
          owner_d     = arb_sel;
          mul_data1_d = a_sel;
          mul_data2_d = b_sel;
          ptr_d       = ptr_next;
          state_d     = START;
        end
      end
      START: begin
        mul_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (mul_done || (cnt_q == CW'(TIMEOUT - 1))) begin
          // done wins over timeout when both happen in the same cycle
          rsp_product_d = mul_done ? mul_product : '0;
          rsp_err_d     = !mul_done;
          rsp_valid_d   = NREQ'(1) << owner_q;
          mul_start_d   = 1'b0;
          mul_rst_n_d   = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rsp_product_d = '0;
        rsp_err_d     = 1'b0;
        state_d       = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      busy        <= 1'b0;
      mul_rst_n   <= 1'b0;
      mul_start   <= 1'b0;
      mul_data1   <= '0;
      mul_data2   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      gnt         <= gnt_d;
      rsp_valid   <= rsp_valid_d;
      rsp_product <= rsp_product_d;
      rsp_err     <= rsp_err_d;
      busy        <= busy_d;
      mul_rst_n   <= mul_rst_n_d;
      mul_start   <= mul_start_d;
      mul_data1   <= mul_data1_d;
      mul_data2   <= mul_data2_d;
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl with a behavioural 10-cycle multiplier and
// grant/response scoreboards.
module tb_mul_share_ctrl;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned LAT     = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err, busy, mul_rst_n, mul_start;
  logic [W-1:0]      mul_data1, mul_data2;
  logic [2*W-1:0]    mul_product;
  logic              mul_done;

  logic              done_en;
  logic              m_run, m_done;
  logic [7:0]        m_cnt;
  logic [2*W-1:0]    m_prod;
  logic              prev_rsp;

  int tests;
  int fails;

  typedef struct { int idx; int a; int b; } gexp_t;
  typedef struct { int idx; int p; int e; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  mul_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .mul_rst_n(mul_rst_n),
    .mul_start(mul_start), .mul_data1(mul_data1), .mul_data2(mul_data2),
    .mul_product(mul_product), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  // Behavioural start/done multiplier with fixed latency
  always @(posedge clk) begin
    if (!mul_rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_prod <= '0;
    end else if (m_run) begin
      if (m_cnt == 8'(LAT - 1)) begin
        m_done <= 1'b1;
        m_prod <= 16'(mul_data1) * 16'(mul_data2);
        m_run  <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 8'd1;
      end
    end else if (mul_start && !m_done) begin
      m_run <= 1'b1;
      m_cnt <= '0;
    end
  end
  assign mul_product = m_prod;
  assign mul_done    = m_done & done_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_product"}, 32'(rsp_product), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_mul_rst_n"}, 32'(mul_rst_n), 0);
    check({tag, "_mul_start"}, 32'(mul_start), 0);
    check({tag, "_data1"}, 32'(mul_data1), 0);
    check({tag, "_data2"}, 32'(mul_data2), 0);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic expect_job(input int i, input int a, input int b, input bit with_rsp);
    gexp_t g;
    rexp_t r;
    g.idx = i; g.a = a; g.b = b;
    gq.push_back(g);
    if (with_rsp) begin
      r.idx = i; r.p = a * b; r.e = 0;
      rq.push_back(r);
    end
  endtask

  task automatic wait_gnt(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 300);
    check($sformatf("gnt_wait%0d", i), 32'(gnt[i]), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || rq.size() != 0) && n < 300);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  // Scoreboard monitor: grants, responses and the multiplier re-arm pulse
  always @(negedge clk) begin : mon
    gexp_t g;
    rexp_t r;
    if (prev_rsp) begin
      check("post_rsp_mul_rst_n", 32'(mul_rst_n), 1);
      check("post_rsp_valid", 32'(rsp_valid), 0);
      check("post_rsp_product", 32'(rsp_product), 0);
      check("post_rsp_start", 32'(mul_start), 0);
    end
    prev_rsp <= (rsp_valid != '0);
    if (gnt !== '0) begin
      check("start_mul_start", 32'(mul_start), 0);
      check("start_mul_rst_n", 32'(mul_rst_n), 1);
      if (gq.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
      else begin
        g = gq.pop_front();
        check("gnt_onehot", 32'(gnt), 32'(1) << g.idx);
        check("mul_data1", 32'(mul_data1), 32'(g.a));
        check("mul_data2", 32'(mul_data2), 32'(g.b));
      end
    end
    if (rsp_valid !== '0) begin
      check("resp_mul_rst_n", 32'(mul_rst_n), 0);
      check("resp_mul_start", 32'(mul_start), 0);
      if (rq.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
      else begin
        r = rq.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1) << r.idx);
        check("rsp_product", 32'(rsp_product), 32'(r.p));
        check("rsp_err", 32'(rsp_err), 32'(r.e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_g, cyc, wcnt;
    rexp_t r;
    tests = 0; fails = 0;
    prev_rsp = 1'b0;
    done_en = 1'b1;
    reset_n = 1'b0; req = '0; a_in = '0; b_in = '0;

    // Reset values, then mul_rst_n releases one cycle later
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check("release_mul_rst_n", 32'(mul_rst_n), 1);
    check("release_busy", 32'(busy), 0);

    // Single request
    set_op(0, 26, 45);
    expect_job(0, 26, 45, 1'b1);
    req[0] = 1'b1;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_idle("single");

    // Two simultaneous requests after reset, then pointer sits at 3
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
    set_op(1, 100, 179); set_op(2, 199, 57);
    expect_job(1, 100, 179, 1'b1);
    expect_job(2, 199, 57, 1'b1);
    req = 4'b0110;
    wait_gnt(1); req[1] = 1'b0;
    wait_gnt(2); req[2] = 1'b0;
    wait_idle("pair");
    set_op(0, 7, 8); set_op(3, 9, 10);
    expect_job(3, 9, 10, 1'b1);
    expect_job(0, 7, 8, 1'b1);
    req = 4'b1001;
    wait_gnt(3); req[3] = 1'b0;
    wait_gnt(0); req[0] = 1'b0;
    wait_idle("ptr3");

    // All requesters held for eight jobs from a fresh pointer
    reset_n = 1'b0; @(negedge clk); reset_n = 1'b1; @(negedge clk);
    set_op(0, 1, 2); set_op(1, 17, 3); set_op(2, 200, 100); set_op(3, 255, 255);
    for (int j = 0; j < 8; j++) begin
      case (j % 4)
        0: expect_job(0, 1, 2, 1'b1);
        1: expect_job(1, 17, 3, 1'b1);
        2: expect_job(2, 200, 100, 1'b1);
        default: expect_job(3, 255, 255, 1'b1);
      endcase
    end
    req = 4'b1111;
    n_g = 0; cyc = 0;
    while (n_g < 8 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        n_g++;
        if (n_g == 8) req = '0;
      end
    end
    req = '0;
    check("eight_grants", 32'(n_g), 8);
    wait_idle("all4");

    // Timeout: done never seen by the controller
    done_en = 1'b0;
    set_op(2, 5, 6);
    expect_job(2, 5, 6, 1'b0);
    r.idx = 2; r.p = 0; r.e = 1;
    rq.push_back(r);
    req[2] = 1'b1;
    wait_gnt(2);
    req[2] = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mul_start && cyc < 10);
    wcnt = 0;
    do begin
      @(negedge clk);
      wcnt++;
    end while (rsp_valid == '0 && wcnt < 200);
    check("timeout_cycles", 32'(wcnt), 64);
    wait_idle("timeout");
    done_en = 1'b1;
    set_op(3, 12, 13);
    expect_job(3, 12, 13, 1'b1);
    req[3] = 1'b1;
    wait_gnt(3);
    req[3] = 1'b0;
    wait_idle("after_timeout");

    // Reset while waiting: job abandoned, re-issued job completes
    set_op(1, 9, 9);
    expect_job(1, 9, 9, 1'b0);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_reset_busy", 32'(busy), 0);
    expect_job(1, 9, 9, 1'b1);
    req[1] = 1'b1;
    wait_gnt(1);
    req[1] = 1'b0;
    wait_idle("reissue");

    repeat (3) @(negedge clk);
    check("gq_empty", 32'(gq.size()), 0);
    check("rq_empty", 32'(rq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
